// File: rtl/bch_syndrome_pkg.sv
// Shared GF(2^M) helpers and state type for the BCH syndrome front end.
// Every helper is a constant function, so it folds into fixed XOR networks when synthesized.
package bch_syndrome_pkg;

  typedef enum logic {IDLE, RECV} state_t;

  // Smallest M such that 2^M - 1 >= n.
  function automatic int n2m(input int n);
    int m;
    m = 1;
    for (int i = 1; i < 16; i++)
      if ((1 << i) - 1 < n) m = i + 1;
    return m;
  endfunction

  // Primitive polynomial for GF(2^m), including the x^m term.
  function automatic int bch_polynomial(input int m);
    case (m)
      2:       return 'b111;
      3:       return 'b1011;
      4:       return 'b10011;
      5:       return 'b100101;
      6:       return 'b1000011;
      7:       return 'b10001001;
      8:       return 'b100011101;
      9:       return 'b1000010001;
      10:      return 'b10000001001;
      default: return 0;
    endcase
  endfunction

  function automatic int mul(input int m, input int a, input int b);
    int p;
    int r;
    p = bch_polynomial(m);
    r = 0;
    for (int i = m - 1; i >= 0; i--) begin
      r = r << 1;
      if (((r >> m) & 1) != 0) r = r ^ p;
      if (((b >> i) & 1) != 0) r = r ^ a;
    end
    return r;
  endfunction

  function automatic int lpow(input int m, input int j);
    int r;
    r = 1;
    for (int i = 0; i < j; i++) r = mul(m, r, 2);
    return r;
  endfunction

endpackage

// File: rtl/bch_syndrome_cell.sv
// One Horner accumulator for r(alpha^J).
// The alpha^J factor is a compile-time constant, so the multiply is a fixed XOR network.
module bch_syndrome_cell
  import bch_syndrome_pkg::*;
#(
  parameter int M = 4,
  parameter int J = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic         din,
  output logic [M-1:0] acc
);

  localparam int ALPHA_J = lpow(M, J);

  // load starts a fresh word from the first bit, so no separate clear is needed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      acc <= '0;
    else if (load)
      acc <= M'(din);
    else if (en)
      acc <= M'(mul(M, int'(acc), ALPHA_J)) ^ M'(din);
  end

endmodule

// File: rtl/bch_syndrome.sv
// Serial BCH syndrome front end: forwards the message bits and computes the odd syndromes.
// Each syndrome S(2i+1) is packed at syndromes[i*M +: M].
module bch_syndrome
  import bch_syndrome_pkg::*;
#(
  parameter int N = 15,
  parameter int K = 5,
  parameter int T = 3,
  localparam int M = n2m(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           din,
  output logic           data_out,
  output logic           data_valid,
  output logic [T*M-1:0] syndromes,
  output logic           syn_valid,
  output logic           err
);

  state_t         state;
  logic [M-1:0]   count;
  logic           last_bit;
  logic           start_eff;
  logic           en;
  logic [M-1:0]   bit_idx;
  logic           msg_bit;
  logic [M-1:0]   acc [T];
  logic [T*M-1:0] final_syn;

  // A start pulse on the last bit does not restart the word.
  always_comb begin
    last_bit  = (state == RECV) && (count == M'(N - 1));
    start_eff = start && !last_bit;
    en        = (state == RECV) && !start_eff;
    bit_idx   = start_eff ? '0 : count;
    msg_bit   = (start_eff || (state == RECV)) && (int'(bit_idx) < K);
  end

  for (genvar g = 0; g < T; g++) begin : g_cell
    localparam int J  = 2 * g + 1;
    localparam int AJ = lpow(M, J);

    bch_syndrome_cell #(.M(M), .J(J)) u_cell (
      .clk  (clk),
      .reset(reset),
      .load (start_eff),
      .en   (en),
      .din  (din),
      .acc  (acc[g])
    );

    // Same step the cell takes on this edge, so the last bit lands in the syndrome output.
    assign final_syn[g*M +: M] = M'(mul(M, int'(acc[g]), AJ)) ^ M'(din);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      syndromes  <= '0;
      err        <= 1'b0;
      syn_valid  <= 1'b0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      syn_valid  <= 1'b0;
      data_valid <= msg_bit;
      data_out   <= msg_bit & din;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RECV;
            count <= M'(1);
          end
        end
        RECV: begin
          if (start_eff) begin
            count <= M'(1);
          end else if (last_bit) begin
            state     <= IDLE;
            count     <= '0;
            syndromes <= final_syn;
            err       <= |final_syn;
            syn_valid <= 1'b1;
          end else begin
            count <= count + M'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bch_syndrome.sv
// Scoreboard bench for bch_syndrome with N=15, K=5, T=3 over GF(16), x^4+x+1.
// The driver queues the expected syndromes and message bits; the monitor checks them as the DUT presents them.
module tb_bch_syndrome;

  localparam int N = 15;
  localparam int K = 5;
  localparam int T = 3;
  localparam int M = 4;
  localparam logic [10:0] GEN = 11'b10100110111;

  typedef struct {
    logic [T*M-1:0] syn;
    logic           err;
    int             cyc;
  } exp_t;

  logic           clk;
  logic           reset;
  logic           start;
  logic           din;
  logic           data_out;
  logic           data_valid;
  logic [T*M-1:0] syndromes;
  logic           syn_valid;
  logic           err;

  int             checks;
  int             failures;
  int             cyc;
  exp_t           exp_q[$];
  logic           msg_q[$];
  logic [T*M-1:0] held_syn;
  logic           held_err;

  bch_syndrome #(.N(N), .K(K), .T(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .data_out  (data_out),
    .data_valid(data_valid),
    .syndromes (syndromes),
    .syn_valid (syn_valid),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Systematic encoder: message in degrees 14..10, parity is (msg * x^10) mod g(x).
  function automatic logic [14:0] encode(input logic [4:0] msg);
    logic [14:0] r;
    r = {msg, 10'b0};
    for (int d = 14; d >= 10; d--)
      if (r[d]) r = r ^ (15'(GEN) << (d - 10));
    return {msg, r[9:0]};
  endfunction

  // Sends nbits of cw, highest degree first; only a complete word queues a syndrome result.
  task automatic applyStimulus(input logic [14:0] cw, input int nbits,
                               input logic [T*M-1:0] exp_syn, input logic start_on_last);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      start = (i == 0) || (start_on_last && i == N - 1);
      din   = cw[14-i];
      if (i < K) msg_q.push_back(cw[14-i]);
      if (i == N - 1) exp_q.push_back('{syn: exp_syn, err: |exp_syn, cyc: cyc + 1});
    end
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      din   = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      held_syn = '0;
      held_err = 1'b0;
    end else begin
      if (syn_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected syn_valid", 32'(syn_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("syndromes", 32'(syndromes), 32'(e.syn));
          checkOutput("err", 32'(err), 32'(e.err));
          checkOutput("syn_valid timing", 32'(cyc), 32'(e.cyc));
          held_syn = e.syn;
          held_err = e.err;
        end
      end else begin
        checkOutput("syndromes held", 32'(syndromes), 32'(held_syn));
        checkOutput("err held", 32'(err), 32'(held_err));
      end
      if (data_valid) begin
        if (msg_q.size() == 0) begin
          checkOutput("unexpected data_valid", 32'(data_valid), 32'd0);
        end else begin
          logic b;
          b = msg_q.pop_front();
          checkOutput("data_out", 32'(data_out), 32'(b));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [14:0] cw;
    checks   = 0;
    failures = 0;
    held_syn = '0;
    held_err = 1'b0;
    reset    = 1'b0;
    start    = 1'b0;
    din      = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset syndromes", 32'(syndromes), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset syn_valid", 32'(syn_valid), 32'd0);
    checkOutput("reset data_valid", 32'(data_valid), 32'd0);
    checkOutput("reset data_out", 32'(data_out), 32'd0);
    reset = 1'b1;
    applyIdle(2);

    $display("[TB] zero word, single errors at degree 0 and 1, back-to-back");
    applyStimulus(15'h0000, N, 12'h000, 1'b0);
    applyStimulus(15'h0001, N, 12'h111, 1'b0);
    applyStimulus(15'h0002, N, 12'h682, 1'b0);
    applyIdle(3);

    $display("[TB] encoded words streamed back-to-back");
    for (int w = 0; w < 40; w++) begin
      cw = encode(5'($urandom_range(0, 31)));
      applyStimulus(cw, N, 12'h000, (w % 7) == 3);
    end
    cw = encode(5'b10110);
    applyStimulus(cw ^ 15'h0002, N, 12'h682, 1'b0);
    applyIdle(3);

    $display("[TB] reset in the middle of a corrupted word");
    applyStimulus(15'h5A5A, 7, 12'h000, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    applyIdle(2);
    checkOutput("mid reset syn_valid", 32'(syn_valid), 32'd0);
    checkOutput("mid reset syndromes", 32'(syndromes), 32'd0);
    reset = 1'b1;
    applyIdle(1);
    applyStimulus(15'h0000, N, 12'h000, 1'b0);
    applyIdle(3);

    $display("[TB] restart at bit 9");
    applyStimulus(15'h7FFF, 9, 12'h000, 1'b0);
    cw = encode(5'b01101);
    applyStimulus(cw ^ 15'h0001, N, 12'h111, 1'b0);
    applyIdle(3);

    for (int i = 0; i < 40 && (exp_q.size() != 0 || msg_q.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    checkOutput("pending syndrome results", 32'(exp_q.size()), 32'd0);
    checkOutput("pending message bits", 32'(msg_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
